// File: rtl/seq_pattern_scan_ctrl_pkg.sv
// Shared types and default widths for the serial pattern scan controller.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int WORD_W_DEF  = 8;
    localparam int PAT_MAX_DEF = 8;
    localparam int LEN_W_DEF   = 4;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/seq_pattern_scan_ctrl_core.sv
// Serial pattern match core: bit history, valid-bit count and registered match.
// match_hit is the same-cycle match decision so the owner can update its
// counter in lockstep with the registered match pulse.
module pattern_match_core
    import seq_scan_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_en,
    input  logic               clear,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic               match_hit
);

    logic [PAT_MAX-1:0] hist_q;
    logic [PAT_MAX-1:0] hist_d;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   vcnt_q;
    logic [LEN_W-1:0]   vcnt_d;

    // Next history / valid count and the compare over the newest cfg_len bits.
    always_comb begin
        hist_d = (hist_q << 1) | PAT_MAX'(bit_in);
        vcnt_d = (vcnt_q >= cfg_len) ? cfg_len : vcnt_q + LEN_W'(1);
        mask   = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(cfg_len));
        end
        match_hit = bit_en && (vcnt_d >= cfg_len) &&
                    ((hist_d & mask) == (cfg_pattern & mask));
    end

    // History shifts only on presented bits; non-overlap restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            vcnt_q <= '0;
            match  <= 1'b0;
        end else if (clear) begin
            hist_q <= '0;
            vcnt_q <= '0;
            match  <= 1'b0;
        end else begin
            match <= match_hit;
            if (bit_en) begin
                hist_q <= hist_d;
                vcnt_q <= (match_hit && !cfg_overlap) ? '0 : vcnt_d;
            end
        end
    end

endmodule

// File: rtl/seq_pattern_scan_ctrl.sv
// Frame sequencer: accepts words, serializes them MSB-first into the match
// core and counts matches per frame.
//   state | meaning
//   IDLE  | waiting for a start with a legal cfg_len
//   LOAD  | in_ready high, waiting for a source word
//   SHIFT | presenting one bit per cycle, MSB first
//   DONE  | one-cycle frame completion pulse
module seq_pattern_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               cfg_err
);

    localparam int IDX_W = $clog2(WORD_W);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  data_q;
    logic               last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               len_ok, start_ok, start_bad, accept;
    logic               bit_en, bit_in, match_hit;

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
        start_ok  = (state_q == IDLE) && start && len_ok;
        start_bad = (state_q == IDLE) && start && !len_ok;
        in_ready  = (state_q == LOAD);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        accept    = in_ready && in_valid;
        bit_en    = (state_q == SHIFT);
        bit_in    = data_q[idx_q];
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (accept) state_d = SHIFT;
            SHIFT:   if (idx_q == '0) state_d = last_q ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, captured word, bit index and latched configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
            end
            if (accept) begin
                data_q <= in_data;
                last_q <= in_last;
                idx_q  <= IDX_W'(WORD_W - 1);
            end else if (bit_en && idx_q != '0) begin
                idx_q <= idx_q - IDX_W'(1);
            end
        end
    end

    // Saturating match counter and the config-error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= start_bad;
            if (start_ok) begin
                match_count <= '0;
            end else if (match_hit && match_count != {CNT_W{1'b1}}) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    pattern_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .clear       (start_ok),
        .cfg_pattern (pat_q),
        .cfg_len     (len_q),
        .cfg_overlap (ovl_q),
        .match       (match_pulse),
        .match_hit   (match_hit)
    );

endmodule

// File: tb/tb_seq_pattern_scan_ctrl.sv
// Bench for seq_pattern_scan_ctrl: directed cases plus random frames, checked
// against a window-scan model of the frame bit stream.
module tb_seq_pattern_scan_ctrl;

    localparam int WORD_W  = 8;
    localparam int PAT_MAX = 8;
    localparam int LEN_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        cfg_pattern = '0;
    logic [3:0]        cfg_len = '0;
    logic              cfg_overlap = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_last = 1'b0;

    logic        in_ready, busy, match_pulse, done, cfg_err;
    logic [15:0] match_count;
    logic        in_ready_s, busy_s, match_pulse_s, done_s, cfg_err_s;
    logic [1:0]  match_count_s;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    bit pend = 1'b0;
    logic [7:0] wq[$];
    bit bits[$];
    bit exp_m[$];

    always #5 clk = ~clk;

    seq_pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
        .done(done), .cfg_err(cfg_err)
    );

    seq_pattern_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .LEN_W(LEN_W), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_s), .busy(busy_s), .match_pulse(match_pulse_s), .match_count(match_count_s),
        .done(done_s), .cfg_err(cfg_err_s)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input bit e_rdy, input bit e_busy, input bit e_done);
        check({tag, ".in_ready"},    32'(in_ready),      32'(e_rdy));
        check({tag, ".busy"},        32'(busy),          32'(e_busy));
        check({tag, ".done"},        32'(done),          32'(e_done));
        check({tag, ".cfg_err"},     32'(cfg_err),       32'(0));
        check({tag, ".match_pulse"}, 32'(match_pulse),   32'(pend));
        check({tag, ".match_count"}, 32'(match_count),   32'(sat(exp_cnt, 16)));
        check({tag, ".pulse_s"},     32'(match_pulse_s), 32'(pend));
        check({tag, ".count_s"},     32'(match_count_s), 32'(sat(exp_cnt, 2)));
        check({tag, ".done_s"},      32'(done_s),        32'(e_done));
    endtask

    // Expected match flag per frame bit: a window of the newest len bits equal to
    // the pattern; without overlap the window must start after the previous hit.
    task automatic build_model(input logic [7:0] pat, input int len, input bit ovl);
        int last_end;
        bit m;
        bits.delete();
        exp_m.delete();
        foreach (wq[w]) for (int b = 7; b >= 0; b--) bits.push_back(wq[w][b]);
        last_end = -1;
        for (int i = 0; i < bits.size(); i++) begin
            m = 1'b0;
            if (i + 1 >= len && (ovl || (i - len + 1) > last_end)) begin
                m = 1'b1;
                for (int j = 0; j < len; j++)
                    if (bits[i - len + 1 + j] != pat[len - 1 - j]) m = 1'b0;
            end
            exp_m.push_back(m);
            if (m) last_end = i;
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with it idle.
    task automatic run_frame(input string tag, input logic [7:0] pat, input int len, input bit ovl);
        int k;
        int stall;
        build_model(pat, len, ovl);
        cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ovl; start = 1'b1;
        @(negedge clk);
        exp_cnt = 0; pend = 1'b0; k = 0;
        foreach (wq[w]) begin
            stall = $urandom_range(0, 2);
            for (int s = 0; s <= stall; s++) begin
                check_cycle({tag, ".load"}, 1'b1, 1'b1, 1'b0);
                pend = 1'b0;
                start = 1'($urandom_range(0, 1));
                cfg_len = 4'($urandom_range(0, 15));
                cfg_pattern = 8'($urandom);
                in_valid = (s == stall);
                in_data  = (s == stall) ? wq[w] : 8'($urandom);
                in_last  = (s == stall) && (w == wq.size() - 1);
                @(negedge clk);
            end
            in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
            for (int b = 0; b < WORD_W; b++) begin
                check_cycle({tag, ".shift"}, 1'b0, 1'b1, 1'b0);
                pend = exp_m[k];
                if (pend) exp_cnt++;
                k++;
                start = 1'($urandom_range(0, 1));
                cfg_overlap = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_cycle({tag, ".done"}, 1'b0, 1'b1, 1'b1);
        pend = 1'b0;
        @(negedge clk);
        check_cycle({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bad_start(input string tag, input int len);
        cfg_len = 4'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".cfg_err"},     32'(cfg_err),     32'(1));
        check({tag, ".busy"},        32'(busy),        32'(0));
        check({tag, ".match_count"}, 32'(match_count), 32'(sat(exp_cnt, 16)));
        @(negedge clk);
        check({tag, ".cfg_err_clr"}, 32'(cfg_err),     32'(0));
        check({tag, ".busy2"},       32'(busy),        32'(0));
    endtask

    initial begin
        #1;
        check("rst.in_ready",    32'(in_ready),    32'(0));
        check("rst.busy",        32'(busy),        32'(0));
        check("rst.match_pulse", 32'(match_pulse), 32'(0));
        check("rst.match_count", 32'(match_count), 32'(0));
        check("rst.done",        32'(done),        32'(0));
        check("rst.cfg_err",     32'(cfg_err),     32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        wq = '{8'b10101010};
        run_frame("nonovl", 8'b101, 3, 1'b0);
        check("nonovl.final", 32'(match_count), 32'(2));

        wq = '{8'b10101010};
        run_frame("ovl", 8'b101, 3, 1'b1);
        check("ovl.final", 32'(match_count), 32'(3));

        wq = '{8'b00000010, 8'b10000000};
        run_frame("span", 8'b101, 3, 1'b0);
        check("span.final", 32'(match_count), 32'(1));

        bad_start("len0", 0);
        bad_start("len9", 9);

        wq = '{8'hFF};
        run_frame("sat", 8'b1, 1, 1'b1);
        check("sat.final16", 32'(match_count),   32'(8));
        check("sat.final2",  32'(match_count_s), 32'(3));

        // Abort mid-frame with reset.
        cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort.in_ready",    32'(in_ready),    32'(0));
        check("abort.busy",        32'(busy),        32'(0));
        check("abort.match_pulse", 32'(match_pulse), 32'(0));
        check("abort.match_count", 32'(match_count), 32'(0));
        check("abort.done",        32'(done),        32'(0));
        check("abort.cfg_err",     32'(cfg_err),     32'(0));
        repeat (2) begin
            @(negedge clk);
            check("abort.no_done", 32'(done), 32'(0));
        end
        rst = 1'b1;
        exp_cnt = 0;
        wq = '{8'b01100110};
        run_frame("post_rst", 8'b11, 2, 1'b0);
        check("post_rst.final", 32'(match_count), 32'(2));

        for (int f = 0; f < 25; f++) begin
            int nw;
            nw = $urandom_range(1, 3);
            wq.delete();
            for (int w = 0; w < nw; w++) wq.push_back(8'($urandom));
            run_frame("rand", 8'($urandom), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_pattern_scan_ctrl.md
Name: seq_pattern_scan_ctrl

Overview:
Controller that sequences a programmable serial pattern detector over framed parallel input data. It accepts words through a valid/ready handshake and serializes each word MSB-first into an internal match core, one bit per cycle. It counts matches in overlapping or non-overlapping mode and reports completion per frame. It sits between a word-oriented source (DMA/FIFO) and status/interrupt logic.

Parameters:
WORD_W, 8, input word width in bits (>=2)
PAT_MAX, 8, maximum pattern length in bits
LEN_W, 4, width of cfg_len (must hold PAT_MAX)
CNT_W, 16, match counter width

Ports:
clk  input  1  clock, all state rising-edge
rst  input  1  reset, asynchronous, active-low
start  input  1  begin frame; sampled only in IDLE
cfg_pattern  input  PAT_MAX  pattern; bit [cfg_len-1] is compared against the oldest bit, bit [0] against the newest
cfg_len  input  LEN_W  pattern length, valid range 1..PAT_MAX
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  source word valid
in_data  input  WORD_W  source word
in_last  input  1  word is the last in the frame
in_ready  output  1  controller can accept a word
busy  output  1  frame in progress (state != IDLE)
match_pulse  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in current/last frame, saturating
done  output  1  one-cycle pulse, frame complete
cfg_err  output  1  one-cycle pulse, start rejected for invalid cfg_len

Behaviour:
- Reset (rst low, async): state=IDLE. All outputs 0. Bit counter, history, valid-bit count and latched config are cleared.
- States:
  - IDLE: start with 1<=cfg_len<=PAT_MAX -> LOAD. The transition latches cfg_pattern/cfg_len/cfg_overlap, clears history and match_count.
  - IDLE: start with cfg_len==0 or >PAT_MAX -> cfg_err=1 next cycle. Stay IDLE. match_count is unchanged.
  - LOAD: in_ready=1 (combinational from state only). On in_valid&&in_ready, capture in_data and in_last, set bit index=WORD_W-1, -> SHIFT.
  - SHIFT: in_ready=0. Each cycle, present in_data[bit index] to the core and decrement the index. After index 0: -> DONE if the captured last flag is set, else -> LOAD.
  - DONE: done=1 for exactly one cycle, -> IDLE.
- Throughput: WORD_W+1 cycles per word minimum (1 LOAD + WORD_W SHIFT). An in_valid stall in LOAD is unbounded.
- Core:
  - Keeps a PAT_MAX-bit history shift register and a valid-bit count (saturates at cfg_len).
  - Match when valid count>=cfg_len and the newest cfg_len history bits equal cfg_pattern[cfg_len-1:0].
  - Match latency: bit presented in cycle t -> match_pulse and incremented match_count visible in cycle t+1 (registered).
- Non-overlap: on a match, valid count resets to 0, so following bits must rebuild a full pattern.
- Overlap: history is retained.
- History persists across word boundaries within a frame. A pattern may span words.
- match_count saturates at 2^CNT_W-1. It holds its value after DONE until the next accepted start.
- done coincides with match_pulse of the final bit if that bit matched. match_count is final in the done cycle.
- start/cfg changes while busy are ignored. Config is used only as latched.
- Reset mid-frame aborts immediately with no done pulse.

Decomposition:
- Package seq_scan_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE} with 2-bit encoding 00/01/10/11.
  - Default widths as localparams.
- Sub-module pattern_match_core:
  - Inputs: bit_in, bit_en, clear, cfg_pattern, cfg_len, cfg_overlap.
  - Outputs: registered match.
  - Owns the history register and valid count.
- Counter and FSM stay in the top.

Test Plan:
- Pattern 3'b101, len 3, non-overlap, one word 8'b10101010 with last -> match_pulse after bits 2 and 6; match_count=2 at done.
- Same stimulus with overlap=1 -> match_pulse after bits 2, 4, 6; match_count=3.
- Span check, pattern 101: word 8'b00000010 then 8'b10000000 (last) -> single match on word 2 bit 7; match_count=1. Check in_ready gaps of exactly WORD_W cycles.
- Invalid config: start with cfg_len=0, then cfg_len=9 -> cfg_err pulses each time; busy stays 0; match_count unchanged.
- Saturation: CNT_W=2, pattern 1'b1, len 1, overlap, word 8'hFF -> match_count stops at 3; eight match_pulses.
- Reset mid-frame: assert rst low during SHIFT -> all outputs 0 asynchronously, no done. A new start after release runs a clean frame with count from 0.
